fpu_top: RTL and testbench



---
 rtl/fpu_top.sv | 167 ++++++++++++++++
 tb/tb_fpu_top.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fpu_top.sv
// Single-precision add/sub/multiply unit: one combinational datapath, result registered.
// Denormals flush to zero and all rounding is truncation toward zero.
module fpu_top (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  op,
  output logic [31:0] out
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Overflow to signed infinity, underflow to signed zero, otherwise pack fields.
  function automatic logic [31:0] pack_sat(input logic s,
                                           input logic signed [9:0] e,
                                           input logic [22:0] m);
    if (e >= 10'sd255)
      pack_sat = {s, 8'hFF, 23'd0};
    else if (e <= 10'sd0)
      pack_sat = {s, 31'd0};
    else
      pack_sat = {s, e[7:0], m};
  endfunction

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic found;
    found = 1'b0;
    lzc27 = 5'd27;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        lzc27 = 5'(26 - i);
        found = 1'b1;
      end
    end
  endfunction

  logic        sa, sb, sb_mul;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

  assign sa     = a[31];
  assign sb_mul = b[31];
  assign sb     = b[31] ^ (op == 2'b01);
  assign ea     = a[30:23];
  assign eb     = b[30:23];
  assign fa     = a[22:0];
  assign fb     = b[22:0];
  assign nan_a  = (ea == 8'hFF) && (fa != 23'd0);
  assign nan_b  = (eb == 8'hFF) && (fb != 23'd0);
  assign inf_a  = (ea == 8'hFF) && (fa == 23'd0);
  assign inf_b  = (eb == 8'hFF) && (fb == 23'd0);
  assign zero_a = (ea == 8'd0);
  assign zero_b = (eb == 8'd0);

  logic               a_big, sl, ss;
  logic [7:0]         el, es, ediff;
  logic [26:0]        ml, ms, ms_sh;
  logic               sticky;
  logic [27:0]        sum;
  logic [4:0]         lz;
  logic [26:0]        norm;
  logic signed [9:0]  add_e;
  logic [22:0]        add_m;
  logic [31:0]        add_res;

  always_comb begin
    a_big = (a[30:0] >= b[30:0]);
    sl    = a_big ? sa : sb;
    ss    = a_big ? sb : sa;
    el    = a_big ? ea : eb;
    es    = a_big ? eb : ea;
    ml    = {1'b1, (a_big ? fa : fb), 3'b000};
    ms    = {1'b1, (a_big ? fb : fa), 3'b000};
    ediff = el - es;
    if (ediff >= 8'd26) begin
      ms_sh  = '0;
      sticky = 1'b1;
    end else begin
      ms_sh  = ms >> ediff;
      sticky = |(ms & ~({27{1'b1}} << ediff));
    end
    // Sticky keeps a subtraction from rounding up when bits were shifted out.
    ms_sh[0] = ms_sh[0] | sticky;
    if (sl == ss)
      sum = {1'b0, ml} + {1'b0, ms_sh};
    else
      sum = {1'b0, ml} - {1'b0, ms_sh};
    lz   = lzc27(sum[26:0]);
    norm = sum[26:0] << lz;
    if (sum[27]) begin
      add_e = $signed({2'b00, el}) + 10'sd1;
      add_m = sum[26:4];
    end else begin
      add_e = $signed({2'b00, el}) - $signed({5'd0, lz});
      add_m = norm[25:3];
    end

    if (nan_a || nan_b)
      add_res = QNAN;
    else if (inf_a && inf_b && (sa != sb))
      add_res = QNAN;
    else if (inf_a)
      add_res = {sa, 8'hFF, 23'd0};
    else if (inf_b)
      add_res = {sb, 8'hFF, 23'd0};
    else if (zero_a && zero_b)
      add_res = {sa & sb, 31'd0};
    else if (zero_a)
      add_res = {sb, b[30:0]};
    else if (zero_b)
      add_res = a;
    else if (sum == 28'd0)
      add_res = 32'd0;
    else
      add_res = pack_sat(sl, add_e, add_m);
  end

  logic               sm;
  logic [47:0]        prod;
  logic signed [9:0]  mul_e;
  logic [22:0]        mul_m;
  logic [31:0]        mul_res;

  always_comb begin
    sm    = sa ^ sb_mul;
    prod  = {24'd0, 1'b1, fa} * {24'd0, 1'b1, fb};
    mul_e = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127
            + (prod[47] ? 10'sd1 : 10'sd0);
    mul_m = prod[47] ? prod[46:24] : prod[45:23];

    if (nan_a || nan_b)
      mul_res = QNAN;
    else if ((inf_a && zero_b) || (inf_b && zero_a))
      mul_res = QNAN;
    else if (inf_a || inf_b)
      mul_res = {sm, 8'hFF, 23'd0};
    else if (zero_a || zero_b)
      mul_res = {sm, 31'd0};
    else
      mul_res = pack_sat(sm, mul_e, mul_m);
  end

  logic [31:0] res_p0;
  logic [31:0] res_p1;

  always_comb begin
    res_p0 = 32'd0;
    case (op)
      2'b00, 2'b01: res_p0 = add_res;
      2'b10:        res_p0 = mul_res;
      default:      res_p0 = 32'd0;
    endcase
  end

  // Stage p0 -> p1: the only register; reset forces a zero result.
  always_ff @(posedge clk) begin
    if (rst)
      res_p1 <= 32'd0;
    else
      res_p1 <= res_p0;
  end

  assign out = res_p1;

endmodule

// File: tb/tb_fpu_top.sv
// Directed bench for fpu_top: reset, add/sub/mul, special values and back-to-back issue.
module tb_fpu_top;

  logic        clk;
  logic        rst;
  logic [31:0] a, b;
  logic [1:0]  op;
  logic [31:0] out;

  int errors = 0;
  int checks = 0;

  fpu_top dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .op  (op),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive operands, let one rising edge capture them, sample 1 time unit later.
  task automatic issue(input logic [31:0] ai, input logic [31:0] bi, input logic [1:0] opi);
    a  = ai;
    b  = bi;
    op = opi;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    issue(32'h3FA0_0000, 32'h3FC0_0000, 2'b00);
    checks++;
    if (out !== 32'h0000_0000) begin
      errors++;
      $display("FAIL reset_edge1 got=%h want=%h", out, 32'h0000_0000);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out !== 32'h0000_0000) begin
      errors++;
      $display("FAIL reset_edge2 got=%h want=%h", out, 32'h0000_0000);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out !== 32'h4030_0000) begin
      errors++;
      $display("FAIL reset_release got=%h want=%h", out, 32'h4030_0000);
    end
  endtask

  task automatic test_add();
    logic [31:0] va [4] = '{32'h0000_0000, 32'h3FA0_0000, 32'h422F_0000, 32'h8000_0000};
    logic [31:0] vb [4] = '{32'h0000_0000, 32'h3FC0_0000, 32'h40A8_0000, 32'h8000_0000};
    logic [31:0] ve [4] = '{32'h0000_0000, 32'h4030_0000, 32'h4244_0000, 32'h8000_0000};
    for (int i = 0; i < 4; i++) begin
      issue(va[i], vb[i], 2'b00);
      checks++;
      if (out !== ve[i]) begin
        errors++;
        $display("FAIL add[%0d] %h+%h got=%h want=%h", i, va[i], vb[i], out, ve[i]);
      end
    end
  endtask

  task automatic test_sub();
    logic [31:0] va [2] = '{32'h3FA0_0000, 32'h4030_0000};
    logic [31:0] vb [2] = '{32'h3FC0_0000, 32'h4030_0000};
    logic [31:0] ve [2] = '{32'hBE80_0000, 32'h0000_0000};
    for (int i = 0; i < 2; i++) begin
      issue(va[i], vb[i], 2'b01);
      checks++;
      if (out !== ve[i]) begin
        errors++;
        $display("FAIL sub[%0d] %h-%h got=%h want=%h", i, va[i], vb[i], out, ve[i]);
      end
    end
  endtask

  task automatic test_mul();
    logic [31:0] va [2] = '{32'h3FA0_0000, 32'hC000_0000};
    logic [31:0] vb [2] = '{32'h3FC0_0000, 32'h4040_0000};
    logic [31:0] ve [2] = '{32'h3FF0_0000, 32'hC0C0_0000};
    for (int i = 0; i < 2; i++) begin
      issue(va[i], vb[i], 2'b10);
      checks++;
      if (out !== ve[i]) begin
        errors++;
        $display("FAIL mul[%0d] %h*%h got=%h want=%h", i, va[i], vb[i], out, ve[i]);
      end
    end
  endtask

  task automatic test_special();
    logic [31:0] va [7] = '{32'h7F80_0000, 32'h7F80_0000, 32'h7F7F_FFFF, 32'h0080_0000,
                           32'h3FA0_0000, 32'h7FA0_0001, 32'h7F80_0000};
    logic [31:0] vb [7] = '{32'hFF80_0000, 32'h0000_0000, 32'h4000_0000, 32'h0080_0000,
                           32'h3FC0_0000, 32'h3F80_0000, 32'hC000_0000};
    logic [1:0]  vo [7] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b11, 2'b00, 2'b10};
    logic [31:0] ve [7] = '{32'h7FC0_0000, 32'h7FC0_0000, 32'h7F80_0000, 32'h0000_0000,
                           32'h0000_0000, 32'h7FC0_0000, 32'hFF80_0000};
    for (int i = 0; i < 7; i++) begin
      issue(va[i], vb[i], vo[i]);
      checks++;
      if (out !== ve[i]) begin
        errors++;
        $display("FAIL special[%0d] a=%h b=%h op=%0d got=%h want=%h",
                 i, va[i], vb[i], vo[i], out, ve[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [3] = '{32'h0000_0000, 32'h3FA0_0000, 32'h422F_0000};
    logic [31:0] vb [3] = '{32'h0000_0000, 32'h3FC0_0000, 32'h40A8_0000};
    logic [31:0] ve [3] = '{32'h0000_0000, 32'h4030_0000, 32'h4244_0000};
    // Seed with a nonzero result so a stale first result is visible.
    issue(32'h3FA0_0000, 32'h3FC0_0000, 2'b10);
    for (int i = 0; i < 3; i++) begin
      a  = va[i];
      b  = vb[i];
      op = 2'b00;
      @(posedge clk);
      #1;
      checks++;
      if (out !== ve[i]) begin
        errors++;
        $display("FAIL b2b[%0d] got=%h want=%h", i, out, ve[i]);
      end
    end
    // Reset mid-stream discards the in-flight result.
    rst = 1'b1;
    issue(32'h3FA0_0000, 32'h3FC0_0000, 2'b10);
    checks++;
    if (out !== 32'h0000_0000) begin
      errors++;
      $display("FAIL b2b_reset got=%h want=%h", out, 32'h0000_0000);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out !== 32'h3FF0_0000) begin
      errors++;
      $display("FAIL b2b_after_reset got=%h want=%h", out, 32'h3FF0_0000);
    end
  endtask

  initial begin
    rst = 1'b1;
    a   = 32'd0;
    b   = 32'd0;
    op  = 2'b00;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_special();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
